// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load/store unit.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_PC4  = 2'b00,
        WB_ALU  = 2'b01,
        WB_LOAD = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_FAULT
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // func3[1:0] is the access size for both loads and stores; 1x is a word
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] natural_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_B:    return off;
            SZ_H:    return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a bus read word and sign- or zero-extends it.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (func3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  result = {24'h0, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_lsu.sv
// Writeback stage: register-file write mux plus a handshaked load/store unit that
// stalls the pipeline while a data-bus access is outstanding.
//
// state   | meaning
// S_IDLE  | no access in flight; non-mem results written back combinationally
// S_REQ   | dbus_req held with stable address/data until dbus_gnt
// S_WAIT  | request accepted, waiting for dbus_rvalid or timeout
// S_RESP  | one cycle, load/store result written back, stall released
// S_FAULT | one cycle, exception pulse toward the CSR unit
module wb_stage_lsu
    import wb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 16,
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              mem_read,
    input  logic              mem_wr,
    input  logic [2:0]        func3,
    input  logic [1:0]        wb_sel,
    input  logic [31:0]       pc,
    input  logic [31:0]       alu_o,
    input  logic [31:0]       store_data,
    input  logic [31:0]       csr_rdata,
    output logic              stall_o,
    output logic [31:0]       wdata,
    output logic              wdata_valid,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_err,
    output logic              exc_valid,
    output logic [3:0]        exc_cause,
    output logic [31:0]       exc_tval
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    lsu_state_e state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic [31:0] load_res;

    logic        mem_op, misalign, tmr_done, resp_ok, resp_fault;
    logic [1:0]  nat_off;
    logic [3:0]  be_calc;
    logic [31:0] wd_calc;

    assign mem_op     = valid_i & (mem_read | mem_wr);
    assign misalign   = ALIGN_CHK && is_misaligned(func3, alu_o[1:0]);
    assign nat_off    = natural_off(func3, alu_o[1:0]);
    assign tmr_done   = (tmr_q == '0);
    assign resp_ok    = dbus_rvalid & ~dbus_err;
    assign resp_fault = (dbus_rvalid & dbus_err) | tmr_done;

    always_comb begin
        be_calc = 4'hF;
        wd_calc = store_data;
        case (func3[1:0])
            SZ_B: begin
                be_calc = 4'b0001 << nat_off;
                wd_calc = {4{store_data[7:0]}};
            end
            SZ_H: begin
                be_calc = 4'b0011 << nat_off;
                wd_calc = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        wdata_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall_o = 1'b1;
                    state_d = misalign ? S_FAULT : S_REQ;
                end else begin
                    wdata_valid = valid_i;
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (dbus_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (resp_ok)         state_d = S_RESP;
                else if (resp_fault) state_d = S_FAULT;
            end
            S_RESP: begin
                wdata_valid = 1'b1;
                state_d     = S_IDLE;
            end
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata  (rdata_q),
        .offset (off_q),
        .func3  (func3_q),
        .result (load_res)
    );

    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_PC4:  wdata = pc + 32'd4;
            WB_ALU:  wdata = alu_o;
            WB_LOAD: wdata = load_res;
            WB_CSR:  wdata = csr_rdata;
            default: wdata = alu_o;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= 4'h0;
            dbus_wdata <= 32'h0;
            exc_valid  <= 1'b0;
            exc_cause  <= 4'h0;
            exc_tval   <= 32'h0;
            tmr_q      <= '0;
            func3_q    <= 3'h0;
            off_q      <= 2'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            exc_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_op && misalign) begin
                        exc_valid <= 1'b1;
                        exc_cause <= mem_wr ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                        exc_tval  <= alu_o;
                    end else if (mem_op) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= mem_wr;
                        dbus_addr  <= {alu_o[ADDR_W-1:2], 2'b00};
                        dbus_be    <= be_calc;
                        dbus_wdata <= wd_calc;
                        func3_q    <= func3;
                        off_q      <= nat_off;
                    end
                end
                S_REQ: begin
                    if (dbus_gnt) begin
                        dbus_req <= 1'b0;
                        tmr_q    <= TMR_LOAD;
                    end
                end
                S_WAIT: begin
                    // dbus_we still holds the op type of the access in flight
                    if (resp_ok) begin
                        rdata_q <= dbus_rdata;
                    end else if (resp_fault) begin
                        exc_valid <= 1'b1;
                        exc_cause <= dbus_we ? EXC_ST_FAULT : EXC_LD_FAULT;
                        exc_tval  <= alu_o;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
